freq_meter: RTL and testbench

- Gate-time frequency counter, the measuring counterpart of the programmable clock divider.
- Counts rising edges of an asynchronous input `sig_in` over a fixed gate window of `inclk` cycles.
- Scales the count to Hz and reports it with a one-cycle valid pulse.
- Used to close the loop on divider outputs and to measure external signals against the 100 MHz system clock.

---
 rtl/freq_meter.sv | 121 ++++++++++++
 tb/tb_freq_meter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gate-time frequency counter: counts synchronized rising edges of sig_in over
// GATE_CYCLES inclk cycles and reports edges*SCALE with a one-cycle valid pulse.
//   state | meaning
//   IDLE  | waiting for enable, no window open
//   GATE  | window open, counting edges
//   DONE  | one-cycle result latch, edges ignored
module freq_meter #(
  parameter int N           = 32,
  parameter int CLK_HZ      = 100000000,
  parameter int GATE_CYCLES = 100000000
) (
  input  logic         inclk,
  input  logic         reset,
  input  logic         sig_in,
  input  logic         enable,
  output logic [N-1:0] freq,
  output logic         freq_valid,
  output logic         overflow,
  output logic         busy
);

  localparam int SCALE = CLK_HZ / GATE_CYCLES;
  localparam int GW    = $clog2(GATE_CYCLES + 1);
  localparam int SW    = $clog2(SCALE + 1);
  // Product is at least 2N wide, wider when SCALE alone exceeds N bits so it can never wrap.
  localparam int PW    = (N + SW > 2 * N) ? N + SW : 2 * N;

  generate
    if (CLK_HZ % GATE_CYCLES != 0) begin : g_bad_ratio
      $error("freq_meter: GATE_CYCLES must divide CLK_HZ exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t        state;
  logic          sync1, sync2, sync3;
  logic          rise;
  logic [GW-1:0] gate_cnt;
  logic [N-1:0]  edge_cnt;
  logic          sat;
  logic [PW-1:0] prod;
  logic          prod_ovf;

  assign rise     = sync2 & ~sync3;
  assign prod     = PW'(edge_cnt) * PW'(SCALE);
  assign prod_ovf = |prod[PW-1:N];

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        GATE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (rise) begin
              if (edge_cnt == '1) sat <= 1'b1;
              else                edge_cnt <= edge_cnt + 1'b1;
            end
            gate_cnt <= gate_cnt + 1'b1;
            if (gate_cnt == GW'(GATE_CYCLES - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          freq       <= prod_ovf ? '1 : prod[N-1:0];
          overflow   <= sat | prod_ovf;
          freq_valid <= 1'b1;
          if (enable) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit/1000-cycle gate, 8-bit/2000-cycle gate)
// checked window by window against an edge-counting reference built from the driven waveform.
module tb_freq_meter;

  localparam int G1   = 1000;
  localparam int G2   = 2000;
  localparam int MAXC = 40000;

  logic        inclk = 1'b0;
  logic        reset, sig_in, en_a, en_b;
  logic [31:0] freq_a;
  logic        val_a, ovf_a, busy_a;
  logic [7:0]  freq_b;
  logic        val_b, ovf_b, busy_b;

  always #5 inclk = ~inclk;

  freq_meter #(.N(32), .CLK_HZ(100000000), .GATE_CYCLES(G1)) dut_a (
    .inclk(inclk), .reset(reset), .sig_in(sig_in), .enable(en_a),
    .freq(freq_a), .freq_valid(val_a), .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter #(.N(8), .CLK_HZ(100000000), .GATE_CYCLES(G2)) dut_b (
    .inclk(inclk), .reset(reset), .sig_in(sig_in), .enable(en_b),
    .freq(freq_b), .freq_valid(val_b), .overflow(ovf_b), .busy(busy_b)
  );

  int     n_tests, n_fail;
  int     cyc, gs;
  bit     sig_val [MAXC];
  int     mode, half, ph;
  bit     lvl, sel_b;
  longint last_freq;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic longint cur_freq();
    return sel_b ? longint'(freq_b) : longint'(freq_a);
  endfunction
  function automatic longint cur_valid();
    return sel_b ? longint'(val_b) : longint'(val_a);
  endfunction
  function automatic longint cur_ovf();
    return sel_b ? longint'(ovf_b) : longint'(ovf_a);
  endfunction
  function automatic longint cur_busy();
    return sel_b ? longint'(busy_b) : longint'(busy_a);
  endfunction

  // A rise driven in slot s reaches the counter at clock edge s+3.
  function automatic longint edges_in(input int a, input int b);
    longint n = 0;
    for (int k = a; k <= b; k++)
      if (k >= 4 && k - 3 < MAXC && sig_val[k-3] && !sig_val[k-4]) n++;
    return n;
  endfunction

  task automatic tick();
    if (cyc < MAXC) sig_val[cyc] = reset ? 1'b0 : sig_in;
    @(posedge inclk);
    cyc++;
    #1;
    if (mode == 0) sig_in = lvl;
    else if (ph == 0) begin
      sig_in = ~sig_in;
      ph = (mode == 1) ? half - 1 : int'($urandom_range(9, 2)) - 1;
    end else ph--;
  endtask

  task automatic windows(input int nw);
    int     g;
    longint scale, maxv, e, p, ef;
    bit     eo;
    g     = sel_b ? G2 : G1;
    scale = 100000000 / g;
    maxv  = sel_b ? 64'd255 : 64'd4294967295;
    for (int m = 0; m < nw; m++) begin
      while (cyc < gs + g - 1) begin
        tick();
        chk("valid_low", cur_valid(), 0);
        if (cyc == gs + g / 2) chk("busy_in_gate", cur_busy(), 1);
      end
      tick();
      e  = edges_in(gs, gs + g - 1);
      p  = (e > maxv ? maxv : e) * scale;
      ef = (p > maxv) ? maxv : p;
      eo = (e > maxv) || (p > maxv);
      chk("valid_pulse", cur_valid(), 1);
      chk("freq", cur_freq(), ef);
      chk("overflow", cur_ovf(), longint'(eo));
      last_freq = ef;
      gs += g + 1;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; gs = 0;
    reset = 1'b1; en_a = 1'b1; en_b = 1'b0; sig_in = 1'b0;
    mode = 1; half = 5; ph = 0; lvl = 1'b0; sel_b = 1'b0; last_freq = 0;

    repeat (6) begin
      tick();
      chk("rst_freq", freq_a, 0);
      chk("rst_valid", val_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_busy", busy_a, 0);
    end
    reset = 1'b0;
    gs = cyc + 2;
    tick();
    chk("busy_after_rst", busy_a, 1);

    windows(3);
    chk("tone_10mhz", freq_a, 10000000);
    chk("tone_no_ovf", ovf_a, 0);

    mode = 0; lvl = 1'b1;
    windows(2);
    chk("static_zero", freq_a, 0);

    mode = 1;
    windows(2);
    chk("tone_again", freq_a, 10000000);

    while (cyc < gs + 499) tick();
    en_a = 1'b0;
    tick();
    chk("abort_busy", busy_a, 0);
    repeat (20) begin
      tick();
      chk("abort_no_valid", val_a, 0);
      chk("abort_hold", freq_a, last_freq);
    end
    chk("abort_hold_10m", freq_a, 10000000);
    en_a = 1'b1;
    gs = cyc + 2;
    windows(1);
    chk("restart_10mhz", freq_a, 10000000);

    mode = 2;
    windows(6);

    mode = 1;
    windows(1);
    while (cyc < gs + 299) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_freq", freq_a, 0);
    chk("mid_rst_valid", val_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    tick();
    chk("mid_rst_hold", freq_a, 0);
    chk("mid_rst_novalid", val_a, 0);
    reset = 1'b0;
    gs = cyc + 2;
    windows(2);
    chk("post_rst_10mhz", freq_a, 10000000);

    en_a = 1'b0;
    sel_b = 1'b1;
    half = 2;
    en_b = 1'b1;
    gs = cyc + 2;
    windows(1);
    chk("sat_freq", freq_b, 255);
    chk("sat_ovf", ovf_b, 1);
    mode = 0; lvl = 1'b0;
    windows(2);
    chk("quiet_freq", freq_b, 0);
    chk("quiet_ovf", ovf_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
